// File: rtl/vga_pkg.sv
// Shared types and timing helpers for the VGA line-buffer core.
package vga_pkg;

    typedef enum logic {S_SYNC, S_DISP} vga_state_e;

    // Total length of a scan line or frame: visible + front porch + sync + back porch.
    function automatic int unsigned scan_total(input int unsigned disp,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return disp + front + sync + back;
    endfunction

    // The frame-start marker sits directly above the packed {r,g,b} word.
    function automatic int unsigned sof_bit(input int unsigned rsize,
                                            input int unsigned gsize,
                                            input int unsigned bsize);
        return rsize + gsize + bsize;
    endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// Single-clock show-ahead FIFO: dout shows the head word whenever empty is low.
module vga_sync_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write,
    input  logic [WIDTH-1:0]           din,
    input  logic                       read,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(DEPTH));
    assign level = count_q;
    assign dout  = mem[rd_ptr_q];

    assign do_wr = write & ~full;
    assign do_rd = read & ~empty;

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vga_core_linebuf_sync.sv
// Single-clock VGA timing core fed from a show-ahead line buffer with SOF alignment.
// Optional VGA_LB_STATS_EN adds saturating underflow/misalignment counters.
module vga_core_linebuf_sync
    import vga_pkg::*;
#(
    parameter int unsigned RSIZE     = 4,
    parameter int unsigned GSIZE     = 4,
    parameter int unsigned BSIZE     = 4,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter logic [RSIZE+GSIZE+BSIZE-1:0] UNDERFLOW_RGB = '0
) (
    input  logic                           pixel_clk,
    input  logic                           pixel_rst_n,
    input  logic [RSIZE+GSIZE+BSIZE:0]     linebuffer_data,
    input  logic                           linebuffer_vld,
    output logic                           linebuffer_rdy,
    output logic [$clog2(DEPTH+1)-1:0]     linebuffer_level,
    output logic                           underflow,
`ifdef VGA_LB_STATS_EN
    output logic [15:0]                    underflow_count,
    output logic [15:0]                    misalign_count,
`endif
    output logic [RSIZE-1:0]               vga_r,
    output logic [GSIZE-1:0]               vga_g,
    output logic [BSIZE-1:0]               vga_b,
    output logic                           vga_hsync,
    output logic                           vga_vsync
);

    localparam int unsigned RGB_SIZE = RSIZE + GSIZE + BSIZE;
    localparam int unsigned SOF      = sof_bit(RSIZE, GSIZE, BSIZE);
    localparam int unsigned H_TOTAL  = scan_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL  = scan_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);

    logic [HW-1:0]       h_cnt_q, h_cnt_d;
    logic [VW-1:0]       v_cnt_q, v_cnt_d;
    vga_state_e          state_q, state_d;
    logic [RGB_SIZE:0]   fifo_dout;
    logic                fifo_empty, fifo_full, fifo_rd, fifo_wr;
    logic [RGB_SIZE-1:0] rgb_q, rgb_d;
    logic                hsync_q, vsync_q, hsync_d, vsync_d;
    logic                underflow_q, underflow_d;
    logic                h_end, v_end, scan_end, disp_end, video_on, at_origin;
    logic                head_sof, misalign;

    assign linebuffer_rdy = ~fifo_full;
    assign fifo_wr        = linebuffer_vld & ~fifo_full;

    vga_sync_fifo #(
        .WIDTH (RGB_SIZE + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (pixel_clk),
        .rst_n (pixel_rst_n),
        .write (fifo_wr),
        .din   (linebuffer_data),
        .read  (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (linebuffer_level)
    );

    assign h_end     = (h_cnt_q == HW'(H_TOTAL - 1));
    assign v_end     = (v_cnt_q == VW'(V_TOTAL - 1));
    assign scan_end  = h_end && v_end;
    assign disp_end  = (h_cnt_q == HW'(H_DISPLAY - 1)) && (v_cnt_q == VW'(V_DISPLAY - 1));
    assign video_on  = (h_cnt_q < HW'(H_DISPLAY)) && (v_cnt_q < VW'(V_DISPLAY));
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign head_sof  = fifo_dout[SOF];

    // A marker anywhere but the first pixel means the source restarted a frame.
    assign misalign  = (state_q == S_DISP) && video_on && !fifo_empty && head_sof && !at_origin;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_end) begin
            h_cnt_d = '0;
            v_cnt_d = v_end ? '0 : v_cnt_q + 1'b1;
        end
    end

    assign hsync_d = ((h_cnt_q >= HW'(H_DISPLAY + H_FRONT)) &&
                      (h_cnt_q <  HW'(H_DISPLAY + H_FRONT + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
    assign vsync_d = ((v_cnt_q >= VW'(V_DISPLAY + V_FRONT)) &&
                      (v_cnt_q <  VW'(V_DISPLAY + V_FRONT + V_SYNC))) ? SYNC_POL : ~SYNC_POL;

    always_comb begin
        state_d     = state_q;
        fifo_rd     = 1'b0;
        rgb_d       = '0;
        underflow_d = 1'b0;
        unique case (state_q)
            S_SYNC: begin
                // Drain stale words until a frame start sits at the head.
                fifo_rd = ~fifo_empty & ~head_sof;
                if (scan_end && !fifo_empty && head_sof) state_d = S_DISP;
            end
            S_DISP: begin
                if (video_on) begin
                    if (fifo_empty) begin
                        rgb_d       = UNDERFLOW_RGB;
                        underflow_d = 1'b1;
                        state_d     = S_SYNC;
                    end else if (misalign) begin
                        state_d = S_SYNC;
                    end else begin
                        fifo_rd = 1'b1;
                        rgb_d   = fifo_dout[RGB_SIZE-1:0];
                        if (disp_end) state_d = S_SYNC;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            state_q     <= S_SYNC;
            rgb_q       <= '0;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            underflow_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            state_q     <= state_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef VGA_LB_STATS_EN
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            underflow_count <= '0;
            misalign_count  <= '0;
        end else begin
            if (underflow_d && underflow_count != 16'hFFFF) underflow_count <= underflow_count + 1'b1;
            if (misalign && misalign_count != 16'hFFFF) misalign_count <= misalign_count + 1'b1;
        end
    end
`endif

    assign vga_r     = rgb_q[RGB_SIZE-1 -: RSIZE];
    assign vga_g     = rgb_q[GSIZE+BSIZE-1 -: GSIZE];
    assign vga_b     = rgb_q[BSIZE-1:0];
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_core_linebuf_sync.sv
// Directed bench for vga_core_linebuf_sync using an 8x4 visible raster (14x7 total).
module tb_vga_core_linebuf_sync;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;
    localparam logic [11:0] UF_RGB = 12'hF0F;

    logic        clk;
    logic        rst_n;
    logic [12:0] lb_data;
    logic        lb_vld;
    logic        lb_rdy;
    logic [4:0]  lb_level;
    logic        underflow;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;
    logic [11:0] rgb;
`ifdef VGA_LB_STATS_EN
    logic [15:0] uf_cnt, ma_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [12:0] q[$];
    bit          fire;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_core_linebuf_sync #(
        .RSIZE (4), .GSIZE (4), .BSIZE (4), .DEPTH (16),
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .SYNC_POL (1'b0), .UNDERFLOW_RGB (UF_RGB)
    ) dut (
        .pixel_clk        (clk),
        .pixel_rst_n      (rst_n),
        .linebuffer_data  (lb_data),
        .linebuffer_vld   (lb_vld),
        .linebuffer_rdy   (lb_rdy),
        .linebuffer_level (lb_level),
        .underflow        (underflow),
`ifdef VGA_LB_STATS_EN
        .underflow_count  (uf_cnt),
        .misalign_count   (ma_cnt),
`endif
        .vga_r            (vga_r),
        .vga_g            (vga_g),
        .vga_b            (vga_b),
        .vga_hsync        (vga_hsync),
        .vga_vsync        (vga_vsync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source model: offers the queue head, retires it once a handshake has happened.
    initial begin
        lb_vld  = 1'b0;
        lb_data = '0;
        fire    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fire   = 1'b0;
                lb_vld = 1'b0;
            end else begin
                if (fire && q.size() > 0) void'(q.pop_front());
                if (q.size() > 0) begin
                    lb_vld  = 1'b1;
                    lb_data = q[0];
                end else begin
                    lb_vld = 1'b0;
                end
                fire = lb_vld && lb_rdy;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_frame(input int len);
        for (int i = 0; i < len; i++) q.push_back({1'(i == 0), 12'(i)});
    endtask

    task automatic test_reset();
        int h, v;
        logic exp_hs, exp_vs;
        rst_n = 1'b0;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sync got hs=%b vs=%b exp 1 1", vga_hsync, vga_vsync);
        end
        tests_run++;
        if (rgb !== 12'h000 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rgb got rgb=%h uf=%b exp 000 0", rgb, underflow);
        end
        tests_run++;
        if (lb_level !== 5'd0 || lb_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_fifo got level=%0d rdy=%b exp 0 1", lb_level, lb_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 2 * FT + 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            h = (n - 1) % HT;
            v = ((n - 1) / HT) % VT;
            exp_hs = (h >= 10 && h < 12) ? 1'b0 : 1'b1;
            exp_vs = (v == 5) ? 1'b0 : 1'b1;
            tests_run++;
            if (vga_hsync !== exp_hs || vga_vsync !== exp_vs) begin
                tests_failed++;
                $display("FAIL idle_sync p=%0d got hs=%b vs=%b exp %b %b",
                         n - 1, vga_hsync, vga_vsync, exp_hs, exp_vs);
            end
            tests_run++;
            if (rgb !== 12'h000 || underflow !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_rgb p=%0d got rgb=%h uf=%b exp 000 0", n - 1, rgb, underflow);
            end
        end
    endtask

    task automatic test_frames();
        int p, h, v, f, pix;
        logic [11:0] exp;
        do_reset();
        repeat (3) push_frame(32);
        for (int n = 1; n <= 5 * FT; n++) begin
            @(posedge clk);
            @(negedge clk);
            p = n - 1; h = p % HT; v = (p / HT) % VT; f = p / FT; pix = v * 8 + h;
            exp = (h < 8 && v < 4 && f >= 1 && f <= 3) ? 12'(pix) : 12'h000;
            tests_run++;
            if (rgb !== exp || underflow !== 1'b0) begin
                tests_failed++;
                $display("FAIL frames_rgb p=%0d got rgb=%h uf=%b exp %h 0", p, rgb, underflow, exp);
            end
        end
    endtask

    task automatic test_stall();
        int p, h, v, f, pix;
        logic [11:0] exp;
        logic exp_uf;
        do_reset();
        push_frame(5);
        for (int n = 1; n <= 4 * FT; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 110) push_frame(32);
            p = n - 1; h = p % HT; v = (p / HT) % VT; f = p / FT; pix = v * 8 + h;
            exp = 12'h000;
            exp_uf = 1'b0;
            if (h < 8 && v < 4) begin
                if (f == 1 && pix < 5) exp = 12'(pix);
                if (f == 1 && pix == 5) begin
                    exp = UF_RGB;
                    exp_uf = 1'b1;
                end
                if (f == 2) exp = 12'(pix);
            end
            tests_run++;
            if (rgb !== exp || underflow !== exp_uf) begin
                tests_failed++;
                $display("FAIL stall_rgb p=%0d got rgb=%h uf=%b exp %h %b", p, rgb, underflow, exp, exp_uf);
            end
        end
`ifdef VGA_LB_STATS_EN
        tests_run++;
        if (uf_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL stall_count got %0d exp 1", uf_cnt);
        end
`endif
    endtask

    task automatic test_misalign();
        int p, h, v, f, pix;
        logic [11:0] exp;
        do_reset();
        push_frame(10);
        push_frame(32);
        push_frame(32);
        for (int n = 1; n <= 5 * FT; n++) begin
            @(posedge clk);
            @(negedge clk);
            p = n - 1; h = p % HT; v = (p / HT) % VT; f = p / FT; pix = v * 8 + h;
            exp = 12'h000;
            if (h < 8 && v < 4) begin
                if (f == 1 && pix < 10) exp = 12'(pix);
                if (f == 2 || f == 3) exp = 12'(pix);
            end
            tests_run++;
            if (rgb !== exp || underflow !== 1'b0) begin
                tests_failed++;
                $display("FAIL misalign_rgb p=%0d got rgb=%h uf=%b exp %h 0", p, rgb, underflow, exp);
            end
        end
`ifdef VGA_LB_STATS_EN
        tests_run++;
        if (ma_cnt !== 16'd1 || uf_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL misalign_count got ma=%0d uf=%0d exp 1 0", ma_cnt, uf_cnt);
        end
`endif
    endtask

    task automatic test_fill();
        do_reset();
        q.push_back({1'b1, 12'h001});
        for (int i = 1; i < 40; i++) q.push_back({1'b0, 12'(i + 1)});
        for (int n = 1; n <= 110; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 60 || n == 98) begin
                tests_run++;
                if (lb_level !== 5'd16 || lb_rdy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fill_full n=%0d got level=%0d rdy=%b exp 16 0", n, lb_level, lb_rdy);
                end
            end
            if (n >= 99 && n <= 106) begin
                tests_run++;
                if (lb_level !== 5'd15 || lb_rdy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL fill_rdwr n=%0d got level=%0d rdy=%b exp 15 1", n, lb_level, lb_rdy);
                end
            end
            if (n == 100) begin
                tests_run++;
                if (rgb !== 12'h002) begin
                    tests_failed++;
                    $display("FAIL fill_pixel got %h exp 002", rgb);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) push_frame(32);
        for (int n = 1; n <= 118; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        tests_run++;
        if (rgb !== 12'd13) begin
            tests_failed++;
            $display("FAIL midrst_pre got %h exp 00d", rgb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rgb !== 12'h000 || underflow !== 1'b0 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_out got rgb=%h uf=%b hs=%b vs=%b exp 000 0 1 1",
                     rgb, underflow, vga_hsync, vga_vsync);
        end
        tests_run++;
        if (lb_level !== 5'd0 || lb_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_fifo got level=%0d rdy=%b exp 0 1", lb_level, lb_rdy);
        end
        q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_frames();
        test_stall();
        test_misalign();
        test_fill();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
